// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_send transmitter between N_REQ byte producers.
// Latches the winner's byte, issues uart_enable (with retry on timeout), and acks on frame end.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   ack,
  output logic               arb_busy,
  output logic               uart_enable,
  output logic [7:0]         uart_data,
  input  logic               uart_busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE,
    ACK
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             arb_busy_q, arb_busy_d;
  logic             uart_enable_q, uart_enable_d;
  logic [7:0]       data_q, data_d;

  logic [7:0]       lane_data [N_REQ];
  logic             found;
  logic [IW-1:0]    pick;

  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    assign lane_data[g] = req_data[8*g +: 8];
  end

  // First requester at or after ptr, wrapping past N_REQ-1.
  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    pick  = ptr_q;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr_q) + k) % N_REQ;
      if (!found && req[IW'(j)]) begin
        found = 1'b1;
        pick  = IW'(j);
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves one unassigned (no latch).
    state_d       = state_q;
    ptr_d         = ptr_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    grant_d       = grant_q;
    data_d        = data_q;
    ack_d         = '0;
    uart_enable_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (found && !uart_busy) begin
          idx_d       = pick;
          data_d      = lane_data[pick];
          grant_d     = '0;
          grant_d[pick] = 1'b1;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        uart_enable_d = 1'b1;
        cnt_d         = '0;
        state_d       = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (uart_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        // Ack is registered, so it shows in the ACK cycle right after busy was first seen low.
        if (!uart_busy) begin
          ack_d[idx_q] = 1'b1;
          state_d      = ACK;
        end
      end
      ACK: begin
        grant_d = '0;
        ptr_d   = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    arb_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      grant_q       <= '0;
      ack_q         <= '0;
      arb_busy_q    <= 1'b0;
      uart_enable_q <= 1'b0;
      data_q        <= 8'h00;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its neighbours.
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      grant_q       <= grant_d;
      ack_q         <= ack_d;
      arb_busy_q    <= arb_busy_d;
      uart_enable_q <= uart_enable_d;
      data_q        <= data_d;
    end
  end

  assign grant       = grant_q;
  assign ack         = ack_q;
  assign arb_busy    = arb_busy_q;
  assign uart_enable = uart_enable_q;
  assign uart_data   = data_q;

endmodule
